vmem_arb: RTL and testbench

VMEM_ARB -- requirements
Module: vmem_arb

---
 rtl/vmem_arb.sv | 86 ++++++++
 tb/tb_vmem_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_arb.sv
// vmem_arb: single-port video memory arbiter (VGA > CPU > screen fill), one-cycle BRAM read latency.
module vmem_arb #(
    parameter int VMEMSTART = 1024,
    parameter int VMEMEND   = 5824,
    parameter int MEMTOP    = 6144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_req,
    input  logic [12:0] vga_addr,
    output logic [7:0]  vga_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        fill_start,
    input  logic [7:0]  fill_value,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_ACK  = 1'b1;
    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_RUN  = 2'd1;
    localparam logic [1:0] F_DONE = 2'd2;
    localparam logic [12:0] L_START = 13'(VMEMSTART);
    localparam logic [12:0] L_LAST  = 13'(VMEMEND - 1);
    localparam logic [12:0] L_TOP   = 13'(MEMTOP);

    logic [0:0]  r_cst;
    logic [1:0]  r_fst;
    logic [12:0] r_ptr, r_last;
    logic [7:0]  r_fval, r_vga_hold;
    logic        r_vga_pend, r_cpu_rd;
    logic        w_vga_gnt, w_cpu_gnt, w_fill_gnt, w_cpu_ok;

    // grants are gated by rst so the port is quiet while reset is asserted
    assign w_vga_gnt  = rst & vga_req;
    assign w_cpu_gnt  = rst & ~vga_req & cpu_req & (r_cst == C_IDLE);
    assign w_fill_gnt = rst & ~vga_req & ~w_cpu_gnt & (r_fst == F_RUN);
    assign w_cpu_ok   = cpu_addr < L_TOP;

    assign mem_addr  = w_vga_gnt ? vga_addr : w_cpu_gnt ? cpu_addr : w_fill_gnt ? r_ptr : r_last;
    assign mem_we    = (w_cpu_gnt & cpu_we & w_cpu_ok) | w_fill_gnt;
    assign mem_wdata = w_cpu_gnt ? cpu_wdata : w_fill_gnt ? r_fval : 8'd0;
    assign vga_data  = r_vga_pend ? mem_rdata : r_vga_hold;
    assign cpu_ack   = r_cst == C_ACK;
    assign cpu_rdata = (cpu_ack & r_cpu_rd) ? mem_rdata : 8'd0;
    assign fill_busy = r_fst != F_IDLE;
    assign fill_done = r_fst == F_DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cst      <= C_IDLE;
            r_fst      <= F_IDLE;
            r_ptr      <= '0;
            r_last     <= '0;
            r_fval     <= '0;
            r_vga_hold <= '0;
            r_vga_pend <= 1'b0;
            r_cpu_rd   <= 1'b0;
        end else begin
            r_last     <= mem_addr;
            r_vga_pend <= vga_req;
            r_vga_hold <= vga_data;
            r_cst      <= w_cpu_gnt ? C_ACK : C_IDLE;
            r_cpu_rd   <= ~cpu_we & w_cpu_ok;
            if (r_fst == F_IDLE && fill_start) begin
                r_fst  <= F_RUN;
                r_fval <= fill_value;
                r_ptr  <= L_START;
            end else if (w_fill_gnt) begin
                r_ptr <= r_ptr + 13'd1;
                if (r_ptr == L_LAST) r_fst <= F_DONE;
            end else if (r_fst == F_DONE) begin
                r_fst <= F_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_vmem_arb.sv
// tb_vmem_arb: randomized scoreboard bench for vmem_arb with a behavioural BRAM and reference memory.
module tb_vmem_arb;
    logic        clk = 1'b0, rst = 1'b0;
    logic        vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, fill_start = 1'b0;
    logic [12:0] vga_addr = '0, cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0, fill_value = '0, mem_rdata = '0;
    logic [7:0]  vga_data, cpu_rdata, mem_wdata;
    logic        cpu_ack, fill_busy, fill_done, mem_we;
    logic [12:0] mem_addr;

    vmem_arb dut (
        .clk(clk), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .fill_start(fill_start), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [7:0] d;} cexp_t;
    cexp_t      cq[$];
    logic [7:0] vq[$];
    logic [7:0] bram [8192];
    logic [7:0] ref_mem [8192];
    int cyc = 0, checks = 0, errors = 0;
    int wr_cnt = 0, first_wr = -1, last_wr = -1, done_cnt = 0, vga_mode = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // behavioural BRAM: read-first, one-cycle latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            chk(int'(mem_addr) < 6144, "we_above_memtop", 32'(mem_addr), 6144);
            bram[mem_addr] <= mem_wdata;
            if (wr_cnt == 0) first_wr = int'(mem_addr);
            wr_cnt++;
            last_wr = int'(mem_addr);
        end
        mem_rdata <= bram[mem_addr];
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (vga_mode)
            0: vga_req = 1'b0;
            1: vga_req = 1'($urandom % 2);
            2: vga_req = ~vga_req;
            default: vga_req = 1'b1;
        endcase
        vga_addr = (vga_mode == 1) ? 13'($urandom % 6144) : 13'($urandom % 1024);
    end

    initial begin
        bit    pv;
        cexp_t e;
        logic [7:0] ve;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (pv) begin
                ve = vq.pop_front();
                chk(vga_data == ve, "vga_data", 32'(vga_data), 32'(ve));
            end
            pv = vga_req && rst;
            if (pv) begin
                vq.push_back(ref_mem[vga_addr]);
                chk(!mem_we && mem_addr == vga_addr, "vga_port", {18'd0, mem_we, mem_addr}, {19'd0, vga_addr});
            end
            if (fill_done) done_cnt++;
            if (cpu_ack) begin
                chk(cq.size() > 0, "cpu_ack_spurious", cq.size(), 1);
                if (cq.size() > 0) begin
                    e = cq.pop_front();
                    chk(cyc == e.c, "cpu_ack_cycle", cyc, e.c);
                    chk(cpu_rdata == e.d, "cpu_rdata", 32'(cpu_rdata), 32'(e.d));
                end
            end
        end
    end

    task automatic cpu_acc(input bit we, input logic [12:0] a, input logic [7:0] d);
        int n;
        bit ok_a, exp_we;
        cexp_t e;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (!vga_req || n > 200) break;
            n++;
        end
        chk(!vga_req, "cpu_grant_timeout", n, 200);
        if (!vga_req) begin
            ok_a   = int'(a) < 6144;
            exp_we = we && ok_a;
            e.c = cyc + 1;
            e.d = (!we && ok_a) ? ref_mem[a] : 8'd0;
            cq.push_back(e);
            chk(mem_we == exp_we, "cpu_gnt_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                chk(mem_addr == a && mem_wdata == d, "cpu_gnt_wr", {11'd0, mem_addr, mem_wdata}, {11'd0, a, d});
                ref_mem[a] = d;
            end
        end
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    task automatic pulse_fill(input logic [7:0] v);
        @(posedge clk);
        #1 fill_value = v; fill_start = 1'b1;
        @(posedge clk);
        #1 fill_start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!fill_done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(fill_done, "fill_done_timeout", n, lim);
    endtask

    task automatic check_text(input logic [7:0] v, input string nm);
        int bad;
        bad = 0;
        for (int i = 1024; i < 5824; i++) if (bram[i] != v) bad++;
        chk(bad == 0, nm, bad, 0);
        for (int i = 1024; i < 5824; i++) ref_mem[i] = v;
    endtask

    initial begin
        int t0, n;
        logic [7:0] v;
        for (int i = 0; i < 8192; i++) begin
            bram[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        #12;
        chk(cpu_ack == 0 && cpu_rdata == 0, "rst_cpu", {cpu_ack, cpu_rdata}, 0);
        chk(vga_data == 0, "rst_vga_data", 32'(vga_data), 0);
        chk(fill_busy == 0 && fill_done == 0, "rst_fill", {fill_busy, fill_done}, 0);
        chk(mem_addr == 0 && mem_we == 0 && mem_wdata == 0, "rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b1;

        cpu_acc(1'b1, 13'd1024, 8'h41);
        cpu_acc(1'b0, 13'd1024, 8'h00);
        chk(ref_mem[1024] == 8'h41, "ref_write_1024", 32'(bram[1024]), 32'h41);
        cpu_acc(1'b0, 13'd6144, 8'h00);
        cpu_acc(1'b1, 13'd7000, 8'hAA);

        @(posedge clk);
        #1 vga_mode = 3;
        @(posedge clk);
        fork
            cpu_acc(1'b0, 13'd200, 8'h00);
            begin
                repeat (10) @(posedge clk);
                #2 vga_mode = 0;
            end
        join

        vga_mode = 1;
        repeat (40) cpu_acc(1'($urandom % 2), 13'($urandom % 6400), 8'($urandom));
        vga_mode = 0;
        repeat (4) @(posedge clk);

        #1 wr_cnt = 0; done_cnt = 0;
        t0 = cyc;
        fill_value = 8'h20; fill_start = 1'b1;
        @(posedge clk);
        #1 fill_start = 1'b0;
        wait_done(6000);
        chk(cyc == t0 + 4801, "fill_done_latency", cyc - t0, 4801);
        chk(wr_cnt == 4800, "fill_write_count", wr_cnt, 4800);
        chk(first_wr == 1024 && last_wr == 5823, "fill_range", {first_wr[15:0], last_wr[15:0]}, {16'd1024, 16'd5823});
        chk(bram[1023] == ref_mem[1023] && bram[5824] == ref_mem[5824], "fill_edges", {bram[1023], bram[5824]}, {ref_mem[1023], ref_mem[5824]});
        check_text(8'h20, "fill1_cells");
        @(negedge clk);
        chk(!fill_busy && !fill_done, "fill_idle_after", {fill_busy, fill_done}, 0);

        v = 8'($urandom);
        wr_cnt = 0; done_cnt = 0; vga_mode = 2;
        pulse_fill(v);
        fork
            begin
                repeat (300) @(posedge clk);
                cpu_acc(1'b0, 13'd100, 8'h00);
                cpu_acc(1'b1, 13'd5823, 8'h77);
                pulse_fill(~v);
            end
        join
        wait_done(20000);
        vga_mode = 0;
        repeat (3) @(negedge clk);
        chk(done_cnt == 1, "fill2_done_count", done_cnt, 1);
        chk(wr_cnt == 4801, "fill2_write_count", wr_cnt, 4801);
        check_text(v, "fill2_cells");

        wr_cnt = 0; done_cnt = 0;
        pulse_fill(8'h33);
        n = 0;
        while (last_wr != 1999 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(last_wr == 1999, "reach_ptr_2000", last_wr, 1999);
        rst = 1'b0;
        #1;
        chk(!fill_busy && !fill_done, "midrst_fill", {fill_busy, fill_done}, 0);
        chk(mem_addr == 0 && !mem_we && mem_wdata == 0, "midrst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk(!cpu_ack && cpu_rdata == 0 && vga_data == 0, "midrst_out", {cpu_ack, cpu_rdata, vga_data}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk(done_cnt == 0 && !fill_busy, "no_done_after_rst", {done_cnt[15:0], 15'd0, fill_busy}, 0);
        wr_cnt = 0;
        pulse_fill(8'h44);
        wait_done(6000);
        chk(first_wr == 1024 && wr_cnt == 4800, "restart_fill", {first_wr[15:0], wr_cnt[15:0]}, {16'd1024, 16'd4800});
        check_text(8'h44, "fill3_cells");

        repeat (4) @(negedge clk);
        chk(cq.size() == 0, "cpu_queue_drained", cq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
